tick_period_meter: RTL
======================

Name: tick_period_meter

Overview:
- Receive-side companion to the free-running tick generator.
- Observes a single-cycle tick stream, measures the interval between consecutive ticks, and reports it in max_cnt encoding (ticks every N+1 cycles read as N).
- Asserts locked once the period has repeated a set number of times; flags loss of tick with a timeout.
- Used by downstream logic to check that a tick source is running at the programmed rate.

Parameters:
- CNT_W, 8, width of interval counter and period output.
- LOCK_CNT, 4, number of consecutive equal periods required to assert locked (legal range 2..15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  synchronous enable; low clears all state to reset values on the next edge.
- tick_in  in  1  tick to measure, synchronous to clk, one cycle high per event.
- period  out  CNT_W  last measured interval in max_cnt encoding, registered.
- period_valid  out  1  one-cycle pulse when period is updated.
- locked  out  1  high while the last LOCK_CNT periods are all equal.
- timeout  out  1  sticky: no tick seen for 2^CNT_W-1 cycles; cleared by the next tick.

Behaviour:
- Reset (reset_n low, asynchronous) and enable low (synchronous) set the following: state ARMED, counter 0, match_cnt 0, period 0, period_valid 0, locked 0, timeout 0.
- States:
  - ARMED: waiting for the first tick.
  - MEASURE: at least one tick seen, not locked.
  - LOCKED.
- Interval counter:
  - Any cycle with tick_in=1 loads 0.
  - Otherwise it increments, saturating at 2^CNT_W-1.
- Example: ticks at cycles 0 and N+1 give counter=N at the cycle N+1 sample.
- ARMED + tick_in:
  - Go to MEASURE, counter:=0.
  - No period_valid; timeout cleared.
- MEASURE/LOCKED + tick_in:
  - period:=counter; period_valid=1 on the following cycle (latency 1 from the tick sample edge).
  - match_cnt:=1 if first measurement or counter != previous period.
  - Otherwise match_cnt:=min(match_cnt+1, LOCK_CNT).
- State and lock transitions:
  - next state LOCKED iff new match_cnt==LOCK_CNT, else MEASURE.
  - locked mirrors state==LOCKED and is registered alongside it.
  - A mismatched period in LOCKED drops locked on the same edge that updates period.
- Timeout:
  - Applies when counter==2^CNT_W-1 in MEASURE or LOCKED with no tick_in.
  - Effect: timeout:=1, state:=ARMED, match_cnt:=0, locked:=0; period holds its last value.
  - No period_valid for the timed-out interval.
  - The next tick clears timeout and restarts from ARMED rules.
- Back-to-back ticks (tick_in high on consecutive cycles) measure period 0 and are legal.
- tick_in held high continuously is a stream of period-0 ticks and locks after LOCK_CNT measurements.
- tick_in coincident with the saturation cycle: the tick wins and is measured as period 2^CNT_W-1; no timeout.
- reset_n asserted mid-lock clears everything immediately, without waiting for clk; the first tick after release is treated as ARMED.
- enable low takes priority over tick_in on the same edge.
- All outputs are driven from flops; no combinational path from tick_in to any output.

Test Plan:
- Ticks every 6 cycles, LOCK_CNT=4:
  - period=5 with period_valid pulse on each tick after the first.
  - locked=1 on the edge of the 4th valid measurement (5th tick).
- Locked at period 5, then one tick arrives 3 cycles early:
  - period=2, locked=0 on that update.
  - Steady period 5 afterwards re-locks after 4 more measurements.
- Two ticks on consecutive cycles, then a third on the next cycle:
  - period=0 twice, match_cnt=2, locked=0.
- Locked at period 10, then tick_in stops:
  - timeout=1 and locked=0 exactly 255 cycles after the last tick; period stays 10.
  - The next tick clears timeout with no period_valid.
- reset_n pulsed low mid-interval while locked:
  - All outputs 0 immediately.
  - The first tick after release produces no period_valid; the second tick gives the correct period.
- enable driven low for 1 cycle while locked with tick_in high on that cycle:
  - All outputs 0 after the edge; the tick is ignored.
  - Measurement restarts from ARMED.

Source files
------------

// File: rtl/tick_period_meter.sv
// Measures the interval between single-cycle ticks, reports it in max_cnt encoding,
// and flags lock when the period repeats and timeout when ticks stop.
module tick_period_meter #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        StArmed,
        StMeasure,
        StLocked
    } state_e;

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [3:0]       LockCnt = 4'(LOCK_CNT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       match_q, match_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (tick_in) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (!enable) begin
            state_d   = StArmed;
            cnt_d     = '0;
            match_d   = '0;
            period_d  = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                StArmed: begin
                    if (tick_in) begin
                        state_d   = StMeasure;
                        timeout_d = 1'b0;
                    end
                end
                StMeasure, StLocked: begin
                    if (tick_in) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        // match_q == 0 marks the first measurement since arming
                        if (match_q == 4'd0 || cnt_q != period_q) begin
                            match_d = 4'd1;
                        end else if (match_q < LockCnt) begin
                            match_d = match_q + 4'd1;
                        end
                        state_d = (match_d == LockCnt) ? StLocked : StMeasure;
                    end else if (cnt_q == CntMax) begin
                        timeout_d = 1'b1;
                        state_d   = StArmed;
                        match_d   = '0;
                    end
                end
                default: state_d = StArmed;
            endcase
        end
        locked_d = (state_d == StLocked);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StArmed;
            cnt_q     <= '0;
            match_q   <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule
